// File: rtl/periodic_enable_pkg.sv
// Shared constants and types for the periodic enable monitor.
package periodic_enable_pkg;

  // LLC cycles per HLC cycle.
  localparam int STAGES = 4;
  localparam int STAGE_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  // Monitor time added per HLC cycle, in ns.
  localparam longint HLC_TICK_NS = 64'sd8000;

  // Period of stream b, in ns.
  localparam longint B_PERIOD_NS = 64'sd100000;

  // Monitor time and counters are 64-bit two's complement and wrap silently.
  typedef logic signed [63:0] time_t;

endpackage

// File: rtl/hlc_clock_gen.sv
// Derives the high-level clock from the low-level clock: a stage counter,
// a registered 50% duty hlc_clock and a tick strobe that is high during
// the LLC cycle whose closing edge brings the stage back to 0.
module hlc_clock_gen
  import periodic_enable_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic hlc_clock,
  output logic tick
);

  logic [STAGE_W-1:0] stage;
  logic [STAGE_W-1:0] stage_next;

  // Next stage value, wrapping at STAGES-1.
  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    stage_next = stage + 1'b1;
    if (stage == STAGE_W'(STAGES - 1)) begin
      stage_next = '0;
    end
  end

  assign tick = en && (stage_next == '0);

  // Stage counter and registered HLC level; hlc_clock follows the next stage.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage     <= STAGE_W'(STAGES - 1);
      hlc_clock <= 1'b0;
    end else if (en) begin
      stage     <= stage_next;
      hlc_clock <= (stage_next < STAGE_W'(STAGES / 2));
    end
  end

endmodule

// File: rtl/periodic_enable_monitor.sv
// RTLola monitor top level: keeps monitor time, the period timer of stream b
// and a one-deep coalescing latch for events on stream a, and raises curEn for
// each HLC cycle that carries a new event or a b deadline.
module periodic_enable_monitor
  import periodic_enable_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  time_t input_a,
  input  logic  new_input,
  output logic  hlc_clock,
  output time_t hlc_clock_cnt,
  output logic  bEn,
  output time_t bTimer,
  output logic  bTimerRst,
  output time_t bTimerCurTime,
  output logic  curEn
);

  logic  tick;
  logic  pending;
  time_t a_cap;
  time_t a_reg;

  time_t t_next;
  logic  b_due;
  logic  ev;
  time_t ev_val;

  hlc_clock_gen u_hlc_clock_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .hlc_clock (hlc_clock),
    .tick      (tick)
  );

  // Deadline test for b and event merge; an event on the tick edge itself wins.
  always_comb begin
    t_next = bTimer + HLC_TICK_NS;
    b_due  = (t_next >= B_PERIOD_NS);
    ev     = pending | new_input;
    ev_val = new_input ? input_a : a_cap;
  end

  // Per-HLC-cycle state updates on the tick, event capture between ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hlc_clock_cnt <= '0;
      bTimerCurTime <= '0;
      bTimer        <= '0;
      bEn           <= 1'b0;
      bTimerRst     <= 1'b0;
      curEn         <= 1'b0;
      pending       <= 1'b0;
      a_cap         <= '0;
      a_reg         <= '0;
    end else if (tick) begin
      hlc_clock_cnt <= hlc_clock_cnt + 64'sd1;
      bTimerCurTime <= bTimerCurTime + HLC_TICK_NS;
      bTimer        <= b_due ? '0 : t_next;
      bEn           <= b_due;
      bTimerRst     <= b_due;
      curEn         <= b_due | ev;
      pending       <= 1'b0;
      if (ev) begin
        a_reg <= ev_val;
      end
    end else if (en && new_input) begin
      // Events between ticks coalesce; the last value wins.
      pending <= 1'b1;
      a_cap   <= input_a;
    end
  end

endmodule

// File: tb/tb_periodic_enable_monitor.sv
// Self-checking bench for periodic_enable_monitor. Timing expectations come
// from closed forms of the edge count; events go through a scoreboard queue
// keyed by the HLC count at which they must appear.
module tb_periodic_enable_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] input_a;
  logic        new_input;
  logic        hlc_clock;
  logic [63:0] hlc_clock_cnt;
  logic        bEn;
  logic [63:0] bTimer;
  logic        bTimerRst;
  logic [63:0] bTimerCurTime;
  logic        curEn;

  periodic_enable_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .input_a       (input_a),
    .new_input     (new_input),
    .hlc_clock     (hlc_clock),
    .hlc_clock_cnt (hlc_clock_cnt),
    .bEn           (bEn),
    .bTimer        (bTimer),
    .bTimerRst     (bTimerRst),
    .bTimerCurTime (bTimerCurTime),
    .curEn         (curEn)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint cnt;
    longint val;
  } ev_t;

  ev_t    exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint edges    = 0;   // enabled edges since reset release
  logic   cur_exp  = 1'b0;
  logic   fired    = 1'b0;
  longint fired_val = 0;

  function automatic longint exp_cnt();
    return (edges + 3) / 4;
  endfunction

  function automatic longint stage_now();
    return (3 + edges) % 4;
  endfunction

  function automatic logic hlc_exp();
    return (stage_now() < 2);
  endfunction

  function automatic logic b_exp();
    return (exp_cnt() > 0) && (exp_cnt() % 13 == 0);
  endfunction

  function automatic longint timer_exp();
    return 8000 * (exp_cnt() % 13);
  endfunction

  // One LLC edge with the given event inputs; updates the reference state.
  task automatic drive_edge(input logic ni, input longint a);
    logic   is_tick;
    longint tgt;
    ev_t    e;
    is_tick   = (stage_now() == 3);
    input_a   = a;
    new_input = ni;
    fired     = 1'b0;
    if (ni && en) begin
      tgt = is_tick ? (edges + 4) / 4 : exp_cnt() + 1;
      if (exp_q.size() > 0 && exp_q[$].cnt == tgt) begin
        void'(exp_q.pop_back());
      end
      e.cnt = tgt;
      e.val = a;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    new_input = 1'b0;
    if (en) begin
      edges++;
      if (is_tick) begin
        if (exp_q.size() > 0 && exp_q[0].cnt == exp_cnt()) begin
          fired     = 1'b1;
          fired_val = exp_q[0].val;
          void'(exp_q.pop_front());
        end
        cur_exp = fired || b_exp();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; new_input = 1'b0; input_a = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (hlc_clock !== 1'b0) begin n_fail++; $display("FAIL reset hlc_clock: got %0b want 0", hlc_clock); end
    n_checks++; if (hlc_clock_cnt !== 64'd0) begin n_fail++; $display("FAIL reset hlc_clock_cnt: got %0d want 0", hlc_clock_cnt); end
    n_checks++; if (bEn !== 1'b0) begin n_fail++; $display("FAIL reset bEn: got %0b want 0", bEn); end
    n_checks++; if (bTimer !== 64'd0) begin n_fail++; $display("FAIL reset bTimer: got %0d want 0", bTimer); end
    n_checks++; if (bTimerRst !== 1'b0) begin n_fail++; $display("FAIL reset bTimerRst: got %0b want 0", bTimerRst); end
    n_checks++; if (bTimerCurTime !== 64'd0) begin n_fail++; $display("FAIL reset bTimerCurTime: got %0d want 0", bTimerCurTime); end
    n_checks++; if (curEn !== 1'b0) begin n_fail++; $display("FAIL reset curEn: got %0b want 0", curEn); end
    n_checks++; if (dut.a_reg !== 64'd0) begin n_fail++; $display("FAIL reset a_reg: got %0d want 0", dut.a_reg); end
    // Release reset while disabled: nothing may move.
    en = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (hlc_clock !== 1'b0) begin n_fail++; $display("FAIL disabled hlc_clock: got %0b want 0", hlc_clock); end
    n_checks++; if (hlc_clock_cnt !== 64'd0) begin n_fail++; $display("FAIL disabled hlc_clock_cnt: got %0d want 0", hlc_clock_cnt); end
    n_checks++; if (bTimerCurTime !== 64'd0) begin n_fail++; $display("FAIL disabled bTimerCurTime: got %0d want 0", bTimerCurTime); end
    edges = 0;
    cur_exp = 1'b0;
  endtask

  task automatic test_hlc_clock();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_edge(1'b0, 0);
      n_checks++; if (hlc_clock !== hlc_exp()) begin n_fail++; $display("FAIL hlc_clock edge %0d: got %0b want %0b", edges, hlc_clock, hlc_exp()); end
      n_checks++; if (hlc_clock_cnt !== exp_cnt()) begin n_fail++; $display("FAIL hlc_clock_cnt edge %0d: got %0d want %0d", edges, hlc_clock_cnt, exp_cnt()); end
      n_checks++; if (bTimerCurTime !== 8000 * exp_cnt()) begin n_fail++; $display("FAIL bTimerCurTime edge %0d: got %0d want %0d", edges, bTimerCurTime, 8000 * exp_cnt()); end
    end
  endtask

  task automatic test_b_period();
    while (edges < 104) begin
      drive_edge(1'b0, 0);
      n_checks++; if (bTimer !== timer_exp()) begin n_fail++; $display("FAIL bTimer cnt %0d: got %0d want %0d", exp_cnt(), bTimer, timer_exp()); end
      n_checks++; if (bEn !== b_exp()) begin n_fail++; $display("FAIL bEn cnt %0d: got %0b want %0b", exp_cnt(), bEn, b_exp()); end
      n_checks++; if (bTimerRst !== b_exp()) begin n_fail++; $display("FAIL bTimerRst cnt %0d: got %0b want %0b", exp_cnt(), bTimerRst, b_exp()); end
      n_checks++; if (curEn !== cur_exp) begin n_fail++; $display("FAIL b curEn cnt %0d: got %0b want %0b", exp_cnt(), curEn, cur_exp); end
      n_checks++; if (bTimerCurTime !== 8000 * exp_cnt()) begin n_fail++; $display("FAIL b curtime cnt %0d: got %0d want %0d", exp_cnt(), bTimerCurTime, 8000 * exp_cnt()); end
    end
  endtask

  task automatic test_events();
    int fires;
    // Single event presented at stage 2.
    while (stage_now() != 2) drive_edge(1'b0, 0);
    drive_edge(1'b1, 5);
    fires = 0;
    for (int k = 0; k < 8; k++) begin
      drive_edge(1'b0, 0);
      if (stage_now() == 0 && curEn === 1'b1) fires++;
      n_checks++; if (curEn !== cur_exp) begin n_fail++; $display("FAIL single curEn edge %0d: got %0b want %0b", edges, curEn, cur_exp); end
      if (fired) begin
        n_checks++; if (dut.a_reg !== fired_val) begin n_fail++; $display("FAIL single a_reg: got %0d want %0d", dut.a_reg, fired_val); end
      end
    end
    n_checks++; if (fires !== 1) begin n_fail++; $display("FAIL single fire count: got %0d want 1", fires); end
    // Two events in one HLC cycle coalesce, last value wins.
    while (stage_now() != 0) drive_edge(1'b0, 0);
    drive_edge(1'b1, 6);
    drive_edge(1'b0, 0);
    drive_edge(1'b1, 7);
    fires = 0;
    for (int k = 0; k < 8; k++) begin
      drive_edge(1'b0, 0);
      if (stage_now() == 0 && curEn === 1'b1) fires++;
      n_checks++; if (curEn !== cur_exp) begin n_fail++; $display("FAIL coalesce curEn edge %0d: got %0b want %0b", edges, curEn, cur_exp); end
      if (fired) begin
        n_checks++; if (dut.a_reg !== fired_val) begin n_fail++; $display("FAIL coalesce a_reg: got %0d want %0d", dut.a_reg, fired_val); end
      end
    end
    n_checks++; if (fires !== 1) begin n_fail++; $display("FAIL coalesce fire count: got %0d want 1", fires); end
  endtask

  task automatic test_enable_freeze();
    while (stage_now() != 1) drive_edge(1'b0, 0);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_edge((k == 4), 99);
      n_checks++; if (hlc_clock !== hlc_exp()) begin n_fail++; $display("FAIL freeze hlc_clock: got %0b want %0b", hlc_clock, hlc_exp()); end
      n_checks++; if (hlc_clock_cnt !== exp_cnt()) begin n_fail++; $display("FAIL freeze cnt: got %0d want %0d", hlc_clock_cnt, exp_cnt()); end
      n_checks++; if (bTimer !== timer_exp()) begin n_fail++; $display("FAIL freeze bTimer: got %0d want %0d", bTimer, timer_exp()); end
    end
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_edge(1'b0, 0);
      n_checks++; if (hlc_clock !== hlc_exp()) begin n_fail++; $display("FAIL resume hlc_clock edge %0d: got %0b want %0b", edges, hlc_clock, hlc_exp()); end
      n_checks++; if (hlc_clock_cnt !== exp_cnt()) begin n_fail++; $display("FAIL resume cnt edge %0d: got %0d want %0d", edges, hlc_clock_cnt, exp_cnt()); end
      n_checks++; if (curEn !== cur_exp) begin n_fail++; $display("FAIL resume curEn edge %0d: got %0b want %0b", edges, curEn, cur_exp); end
    end
  endtask

  task automatic test_simultaneous();
    int budget;
    budget = 0;
    while (!(stage_now() == 3 && exp_cnt() == 38) && budget < 400) begin
      drive_edge(1'b0, 0);
      budget++;
    end
    n_checks++; if (budget >= 400) begin n_fail++; $display("FAIL simul align: got %0d edges want <400", budget); end
    drive_edge(1'b1, 9);
    n_checks++; if (hlc_clock_cnt !== 64'd39) begin n_fail++; $display("FAIL simul cnt: got %0d want 39", hlc_clock_cnt); end
    n_checks++; if (bEn !== 1'b1) begin n_fail++; $display("FAIL simul bEn: got %0b want 1", bEn); end
    n_checks++; if (curEn !== 1'b1) begin n_fail++; $display("FAIL simul curEn: got %0b want 1", curEn); end
    n_checks++; if (dut.a_reg !== 64'd9) begin n_fail++; $display("FAIL simul a_reg: got %0d want 9", dut.a_reg); end
    for (int k = 0; k < 4; k++) begin
      drive_edge(1'b0, 0);
      n_checks++; if (curEn !== cur_exp) begin n_fail++; $display("FAIL simul hold curEn edge %0d: got %0b want %0b", edges, curEn, cur_exp); end
      n_checks++; if (bEn !== b_exp()) begin n_fail++; $display("FAIL simul hold bEn edge %0d: got %0b want %0b", edges, bEn, b_exp()); end
    end
    n_checks++; if (curEn !== 1'b0) begin n_fail++; $display("FAIL simul repeat curEn at cnt 40: got %0b want 0", curEn); end
  endtask

  task automatic test_reset_mid();
    while (stage_now() != 0) drive_edge(1'b0, 0);
    drive_edge(1'b1, 42);
    n_checks++; if (dut.pending !== 1'b1) begin n_fail++; $display("FAIL mid pending set: got %0b want 1", dut.pending); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (hlc_clock_cnt !== 64'd0) begin n_fail++; $display("FAIL mid rst cnt: got %0d want 0", hlc_clock_cnt); end
    n_checks++; if (bTimerCurTime !== 64'd0) begin n_fail++; $display("FAIL mid rst curtime: got %0d want 0", bTimerCurTime); end
    n_checks++; if (bTimer !== 64'd0) begin n_fail++; $display("FAIL mid rst bTimer: got %0d want 0", bTimer); end
    n_checks++; if (hlc_clock !== 1'b0) begin n_fail++; $display("FAIL mid rst hlc_clock: got %0b want 0", hlc_clock); end
    n_checks++; if (dut.pending !== 1'b0) begin n_fail++; $display("FAIL mid rst pending: got %0b want 0", dut.pending); end
    #2 rst = 1'b1;
    edges = 0;
    cur_exp = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      drive_edge(1'b0, 0);
      n_checks++; if (hlc_clock_cnt !== exp_cnt()) begin n_fail++; $display("FAIL post rst cnt edge %0d: got %0d want %0d", edges, hlc_clock_cnt, exp_cnt()); end
      n_checks++; if (curEn !== 1'b0) begin n_fail++; $display("FAIL post rst curEn edge %0d: got %0b want 0", edges, curEn); end
      n_checks++; if (hlc_clock !== hlc_exp()) begin n_fail++; $display("FAIL post rst hlc_clock edge %0d: got %0b want %0b", edges, hlc_clock, hlc_exp()); end
    end
  endtask

  initial begin
    test_reset();
    test_hlc_clock();
    test_b_period();
    test_events();
    test_enable_freeze();
    test_simultaneous();
    test_reset_mid();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
